// File: rtl/felica_pkg.sv
// Shared types and constants for the FeliCa reader transmitter: FSM states,
// sync word, CRC-16/CCITT parameters and the byte-wide CRC update.
package felica_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    DATA,
    CRC
  } txState_e;

  localparam logic [15:0] SYNC_WORD = 16'hB24D;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'h0000;

  localparam int HALF_BIT_212 = 32;
  localparam int HALF_BIT_424 = 16;
  localparam int HALF_DIV     = HALF_BIT_212 / HALF_BIT_424;

  // Feeds one byte MSB first through the 0x1021 polynomial, no reflection.
  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/felica_crc16.sv
// CRC-16/CCITT accumulator: one payload byte per enable, synchronous clear.
module felica_crc16
  import felica_pkg::*;
(
  input  logic        ck_1356meg,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16Byte(crc_q, data_i);
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/felica_reader_tx.sv
// FeliCa reader-mode transmitter: preamble, sync, payload and optional CRC,
// Manchester coded onto mod_out. Define FELICA_TX_CRC_EN to append the CRC.
module felica_reader_tx
  import felica_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 6,
  parameter int HALF_212       = HALF_BIT_212
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       speed,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

`ifdef FELICA_TX_CRC_EN
  localparam bit CRC_ENABLED = 1'b1;
`else
  localparam bit CRC_ENABLED = 1'b0;
`endif

  localparam int CW = $clog2(HALF_212);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);

  txState_e state_q, state_d;
  logic [CW-1:0] halfCnt_q, halfCnt_d;
  logic halfSel_q, halfSel_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] byteCnt_q, byteCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic holdFull_q, holdFull_d;
  logic holdLast_q, holdLast_d;
  logic curLast_q, curLast_d;
  logic speed_q, speed_d;
  logic done_q, done_d;
  logic underrun_q, underrun_d;

  logic [CW-1:0] halfMax;
  logic halfLast, byteEnd, abortNow, readyInt, accept;
  logic crcClear, crcEn;
  logic [15:0] crcValue;

  assign halfMax  = speed_q ? CW'(HALF_212 / HALF_DIV - 1) : CW'(HALF_212 - 1);
  assign halfLast = (halfCnt_q == halfMax);
  assign byteEnd  = halfLast && halfSel_q && (bitCnt_q == 3'd7);
  // A starved byte boundary aborts, and the handshake is refused in that same cycle.
  assign abortNow = (state_q == DATA) && byteEnd && !curLast_q && !holdFull_q;
  assign readyInt = !holdFull_q && !curLast_q && (state_q != CRC) && !abortNow;
  assign accept   = tx_valid && readyInt;

  felica_crc16 u_crc (
    .ck_1356meg (ck_1356meg),
    .rst        (rst),
    .clear_i    (crcClear),
    .en_i       (crcEn),
    .data_i     (hold_q),
    .crc_o      (crcValue)
  );

  always_comb begin
    state_d    = state_q;
    halfCnt_d  = halfCnt_q;
    halfSel_d  = halfSel_q;
    bitCnt_d   = bitCnt_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    holdLast_d = holdLast_q;
    curLast_d  = curLast_q;
    speed_d    = speed_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    crcClear   = 1'b0;
    crcEn      = 1'b0;

    if (accept) begin
      hold_d     = tx_data;
      holdFull_d = 1'b1;
      holdLast_d = tx_last;
    end

    if (state_q != IDLE) begin
      if (halfLast) begin
        halfCnt_d = '0;
        halfSel_d = ~halfSel_q;
        if (halfSel_q) begin
          bitCnt_d = bitCnt_q + 3'd1;
          shift_d  = {shift_q[6:0], 1'b0};
        end
      end else begin
        halfCnt_d = halfCnt_q + 1'b1;
      end
    end

    // Byte boundaries reload the shifter; the counters have already wrapped to zero.
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = PREAMBLE;
          shift_d   = 8'h00;
          byteCnt_d = '0;
          speed_d   = speed;
          curLast_d = 1'b0;
        end
      end
      PREAMBLE: begin
        if (byteEnd) begin
          if (byteCnt_q == PRE_LAST) begin
            state_d   = SYNC;
            byteCnt_d = '0;
            shift_d   = SYNC_WORD[15:8];
          end else begin
            byteCnt_d = byteCnt_q + 8'd1;
          end
        end
      end
      SYNC: begin
        if (byteEnd) begin
          if (byteCnt_q == 8'd0) begin
            shift_d   = SYNC_WORD[7:0];
            byteCnt_d = 8'd1;
          end else begin
            state_d    = DATA;
            byteCnt_d  = '0;
            shift_d    = hold_q;
            holdFull_d = 1'b0;
            curLast_d  = holdLast_q;
            crcEn      = 1'b1;
          end
        end
      end
      DATA: begin
        if (byteEnd) begin
          if (curLast_q) begin
            if (CRC_ENABLED) begin
              state_d   = CRC;
              byteCnt_d = '0;
              shift_d   = crcValue[15:8];
            end else begin
              state_d   = IDLE;
              done_d    = 1'b1;
              crcClear  = 1'b1;
              curLast_d = 1'b0;
            end
          end else if (holdFull_q) begin
            shift_d    = hold_q;
            holdFull_d = 1'b0;
            curLast_d  = holdLast_q;
            crcEn      = 1'b1;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
            crcClear   = 1'b1;
          end
        end
      end
      CRC: begin
        if (byteEnd) begin
          if (byteCnt_q == 8'd0) begin
            shift_d   = crcValue[7:0];
            byteCnt_d = 8'd1;
          end else begin
            state_d   = IDLE;
            byteCnt_d = '0;
            done_d    = 1'b1;
            crcClear  = 1'b1;
            curLast_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q    <= IDLE;
      halfCnt_q  <= '0;
      halfSel_q  <= 1'b0;
      bitCnt_q   <= '0;
      byteCnt_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      holdLast_q <= 1'b0;
      curLast_q  <= 1'b0;
      speed_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      halfCnt_q  <= halfCnt_d;
      halfSel_q  <= halfSel_d;
      bitCnt_q   <= bitCnt_d;
      byteCnt_q  <= byteCnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      holdLast_q <= holdLast_d;
      curLast_q  <= curLast_d;
      speed_q    <= speed_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  // Outputs are masked by rst so they read idle for the whole reset window.
  assign busy     = !rst && (state_q != IDLE);
  assign mod_out  = busy && (shift_q[7] ^ halfSel_q);
  assign done     = !rst && done_q;
  assign underrun = !rst && underrun_q;
  assign tx_ready = rst || readyInt;

endmodule

// File: tb/tb_felica_reader_tx.sv
// Self-checking bench for felica_reader_tx: a frame-level model expands bytes
// into expected per-cycle mod_out; a single checker compares every busy cycle.
module tb_felica_reader_tx;

  localparam int PB = 6;
  localparam int END_NONE = 0;
  localparam int END_DONE = 1;
  localparam int END_UNDERRUN = 2;
`ifdef FELICA_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic ck_1356meg = 1'b0;
  logic rst = 1'b1;
  logic speed = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic tx_ready, mod_out, busy, done, underrun;

  int compared = 0;
  int mismatched = 0;
  bit expQ[$];
  bit expBit;
  bit endPending = 1'b0;
  int endKind = END_NONE;
  int busyCycles = 0;
  int doneCount = 0;
  int underrunCount = 0;
  int poppedCycles = 0;
  logic [7:0] payload[$];

  felica_reader_tx #(.PREAMBLE_BYTES(PB), .HALF_212(32)) dut (
    .ck_1356meg (ck_1356meg),
    .rst        (rst),
    .speed      (speed),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .mod_out    (mod_out),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC as the remainder of payload * x^16 divided by x^16 + x^12 + x^5 + 1.
  function automatic logic [15:0] crcModel(input int n);
    logic [16:0] rem;
    bit inBit;
    rem = '0;
    for (int i = 0; i < n + 2; i++) begin
      for (int b = 7; b >= 0; b--) begin
        inBit = (i < n) ? payload[i][b] : 1'b0;
        rem = {rem[15:0], inBit};
        if (rem[16]) rem = rem ^ 17'h11021;
      end
    end
    return rem[15:0];
  endfunction

  function automatic void buildExpected(input bit spd, input bit withCrc, input int n);
    logic [7:0] frame[$];
    logic [15:0] c;
    int h;
    h = spd ? 16 : 32;
    expQ.delete();
    for (int i = 0; i < PB; i++) frame.push_back(8'h00);
    frame.push_back(8'hB2);
    frame.push_back(8'h4D);
    for (int i = 0; i < n; i++) frame.push_back(payload[i]);
    if (withCrc) begin
      c = crcModel(n);
      frame.push_back(c[15:8]);
      frame.push_back(c[7:0]);
    end
    foreach (frame[i]) begin
      for (int b = 7; b >= 0; b--) begin
        for (int k = 0; k < h; k++) expQ.push_back(frame[i][b]);
        for (int k = 0; k < h; k++) expQ.push_back(~frame[i][b]);
      end
    end
  endfunction

  // Every frame cycle must match the model; the cycle after it shows how the frame ended.
  always @(posedge ck_1356meg) begin
    #1;
    if (busy) busyCycles++;
    if (done) doneCount++;
    if (underrun) underrunCount++;
    if (expQ.size() > 0) begin
      expBit = expQ.pop_front();
      poppedCycles++;
      checkOutput("frame cycle {busy,mod,done,underrun}",
                  {28'd0, busy, mod_out, done, underrun}, {28'd0, 1'b1, expBit, 2'b00});
      if (expQ.size() == 0) endPending = 1'b1;
    end else if (endPending) begin
      endPending = 1'b0;
      if (endKind == END_DONE)
        checkOutput("frame end {busy,mod,done,underrun,ready}",
                    {27'd0, busy, mod_out, done, underrun, tx_ready}, 32'b00101);
      else if (endKind == END_UNDERRUN)
        checkOutput("abort {busy,mod,done,underrun,ready}",
                    {27'd0, busy, mod_out, done, underrun, tx_ready}, 32'b00011);
    end
  end

  task automatic sendByte(input logic [7:0] d, input bit last);
    int t;
    tx_data = d;
    tx_last = last;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 20000) begin
      @(negedge ck_1356meg);
      t++;
    end
    if (!tx_ready) checkOutput("payload ready timeout", 0, 1);
    @(negedge ck_1356meg);
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic applyStimulus(input bit spd, input int nBytes, input int lastIdx,
                               input int endK, input int nModel);
    int t;
    busyCycles = 0;
    doneCount = 0;
    underrunCount = 0;
    poppedCycles = 0;
    @(negedge ck_1356meg);
    speed = spd;
    tx_data = payload[0];
    tx_last = (lastIdx == 0);
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge ck_1356meg);
      t++;
    end
    if (!tx_ready) checkOutput("first byte ready", 0, 1);
    buildExpected(spd, (endK == END_DONE) && CRC_ON, nModel);
    endKind = endK;
    endPending = 1'b0;
    @(negedge ck_1356meg);
    tx_valid = 1'b0;
    tx_last = 1'b0;
    for (int i = 1; i < nBytes; i++) sendByte(payload[i], i == lastIdx);
    t = 0;
    while ((expQ.size() > 0 || endPending) && t < 20000) begin
      @(negedge ck_1356meg);
      t++;
    end
    if (t >= 20000) checkOutput("frame end timeout", 0, 1);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge ck_1356meg);
    checkOutput("in reset {busy,mod,done,underrun,ready}",
                {27'd0, busy, mod_out, done, underrun, tx_ready}, 32'b00001);
    rst = 1'b0;
    @(negedge ck_1356meg);
    checkOutput("idle {busy,mod,done,underrun,ready}",
                {27'd0, busy, mod_out, done, underrun, tx_ready}, 32'b00001);

    // Pin the model to hand-computed values
    payload = '{8'h06, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    checkOutput("model crc", {16'd0, crcModel(6)}, 32'h0921);
    buildExpected(0, 1, 6);
    checkOutput("model length 212 crc", expQ.size(), 8192);
    buildExpected(1, 1, 6);
    checkOutput("model length 424 crc", expQ.size(), 4096);
    buildExpected(0, 0, 6);
    checkOutput("model length 212 plain", expQ.size(), 7168);
    checkOutput("model preamble tail", {31'd0, expQ[3071]}, 1);
    checkOutput("model sync first half", {31'd0, expQ[3072]}, 1);
    checkOutput("model sync second half", {31'd0, expQ[3104]}, 0);
    expQ.delete();

    // 212 kbps polling frame
    applyStimulus(0, 6, 5, END_DONE, 6);
    checkOutput("busy cycles 212", busyCycles, CRC_ON ? 8192 : 7168);
    checkOutput("done pulses 212", doneCount, 1);
    checkOutput("underrun pulses 212", underrunCount, 0);

    // 424 kbps, same bytes
    applyStimulus(1, 6, 5, END_DONE, 6);
    checkOutput("busy cycles 424", busyCycles, CRC_ON ? 4096 : 3584);
    checkOutput("done pulses 424", doneCount, 1);

    // Speed toggled mid-frame is ignored
    fork
      applyStimulus(0, 6, 5, END_DONE, 6);
      begin
        repeat (100) @(negedge ck_1356meg);
        speed = 1'b1;
        repeat (300) @(negedge ck_1356meg);
        speed = 1'b0;
      end
    join
    checkOutput("busy cycles speed toggle", busyCycles, CRC_ON ? 8192 : 7168);

    // Underrun: 02 AA then starve; a byte offered in the abort cycle is refused
    payload = '{8'h02, 8'hAA};
    fork
      applyStimulus(0, 2, -1, END_UNDERRUN, 2);
      begin
        t = 0;
        @(negedge ck_1356meg);
        while (!(expQ.size() == 0 && endPending) && t < 20000) begin
          @(negedge ck_1356meg);
          t++;
        end
        tx_data = 8'h55;
        tx_last = 1'b1;
        tx_valid = 1'b1;
        @(negedge ck_1356meg);
        tx_valid = 1'b0;
        tx_last = 1'b0;
      end
    join
    checkOutput("underrun pulses", underrunCount, 1);
    checkOutput("done after abort", doneCount, 0);
    repeat (3) @(negedge ck_1356meg);
    checkOutput("no accept in abort cycle", {31'd0, busy}, 0);

    // Reset at cycle 3000 of a frame
    payload = '{8'h06, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    doneCount = 0;
    underrunCount = 0;
    poppedCycles = 0;
    @(negedge ck_1356meg);
    speed = 1'b0;
    tx_data = 8'h06;
    tx_last = 1'b0;
    tx_valid = 1'b1;
    buildExpected(0, 0, 1);
    endKind = END_NONE;
    endPending = 1'b0;
    @(negedge ck_1356meg);
    tx_valid = 1'b0;
    t = 0;
    while (poppedCycles < 3000 && t < 10000) begin
      @(negedge ck_1356meg);
      t++;
    end
    checkOutput("cycles before reset", poppedCycles, 3000);
    rst = 1'b1;
    expQ.delete();
    endPending = 1'b0;
    @(posedge ck_1356meg);
    #1;
    checkOutput("mod_out after reset", {31'd0, mod_out}, 0);
    checkOutput("busy after reset", {31'd0, busy}, 0);
    repeat (3) @(negedge ck_1356meg);
    rst = 1'b0;
    repeat (20) @(negedge ck_1356meg);
    checkOutput("done after reset", doneCount, 0);
    checkOutput("underrun after reset", underrunCount, 0);
    checkOutput("idle after reset {busy,mod,ready}",
                {29'd0, busy, mod_out, tx_ready}, 32'b001);

    // Clean frame after reset
    applyStimulus(1, 6, 5, END_DONE, 6);
    checkOutput("busy cycles after reset", busyCycles, CRC_ON ? 4096 : 3584);
    checkOutput("done pulses after reset", doneCount, 1);

    repeat (5) @(negedge ck_1356meg);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/felica_reader_tx.md
FELICA_READER_TX -- requirements
Module: felica_reader_tx

Interface
REQ-001 The block SHALL have parameter PREAMBLE_BYTES, default 6, giving the number of 0x00 preamble bytes sent before sync.
REQ-002 The block SHALL have parameter HALF_212, default 32, giving carrier cycles per half-bit at 212 kbps; the 424 kbps half-bit SHALL be HALF_212/2.
REQ-003 ck_1356meg  in  1  13.56 MHz carrier clock; the only clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 speed  in  1  0 = 212 kbps (fc/64), 1 = 424 kbps (fc/32); sampled only when a frame starts.
REQ-006 tx_data  in  8  payload byte from ARM (length byte first), sent MSB first.
REQ-007 tx_valid  in  1  tx_data is valid.
REQ-008 tx_last  in  1  qualifies tx_data as the final payload byte.
REQ-009 tx_ready  out  1  holding register empty; a byte is accepted when tx_valid and tx_ready are both high.
REQ-010 mod_out  out  1  1 = carrier reduced (drives pwr_oe lines in reader mode).
REQ-011 busy  out  1  frame in progress.
REQ-012 done  out  1  one-cycle pulse after the final half-bit of a frame.
REQ-013 underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-014 The FSM SHALL have states IDLE, PREAMBLE, SYNC, DATA, CRC.
- IDLE -> PREAMBLE on the first accepted byte; the byte is held and speed is latched.
- PREAMBLE -> SYNC after PREAMBLE_BYTES*8 bits.
- SYNC sends 0xB2 then 0x4D, then -> DATA.
- DATA -> CRC after the byte tagged tx_last.
- CRC sends 16 bits, MSB first, then -> IDLE with done.
REQ-015 Manchester coding SHALL drive bit b as mod_out = b for the first half-bit and ~b for the second half-bit.
REQ-016 The half-bit counter SHALL count 0..H-1 (H = 32 or 16) and SHALL wrap with no dead cycles between bits or bytes.
REQ-017 The first half-bit of the first preamble bit SHALL appear on mod_out in the cycle after the first byte is accepted.
REQ-018 The block SHALL keep one holding register plus one shift register.
- tx_ready = holding register empty and state != CRC.
- The shift register loads from the holding register on the last cycle of each byte.
REQ-019 If DATA needs the next byte at a byte boundary and the holding register is empty, the block SHALL abort.
- mod_out = 0 from the next cycle, underrun pulses, state -> IDLE, CRC cleared.
REQ-020 tx_valid in the same cycle as the abort SHALL NOT be accepted.
REQ-021 A byte accepted in the final CRC cycle SHALL be impossible (tx_ready low in CRC); tx_data offered during CRC SHALL wait for IDLE.
REQ-022 CRC SHALL be CRC-16/CCITT: polynomial 0x1021, init 0x0000, no reflection, no final XOR.
- Coverage: payload bytes only (length through last data byte); preamble and sync excluded.
- Update: one payload byte per byte-load, 16-bit result.
REQ-023 In IDLE, mod_out SHALL be 0, busy 0, tx_ready 1.
REQ-024 A change on speed mid-frame SHALL be ignored.

Reset
REQ-025 While rst is high, the block SHALL force state = IDLE, mod_out = 0, busy = 0, done = 0, underrun = 0, tx_ready = 1, counters = 0, CRC = 0x0000, holding register empty.
REQ-026 Reset asserted mid-frame SHALL end modulation in the cycle after rst is sampled and SHALL NOT pulse done or underrun.

Configuration
REQ-027 With FELICA_TX_CRC_EN defined, the CRC state SHALL be generated and sent (REQ-022).
REQ-028 Without FELICA_TX_CRC_EN, the CRC state SHALL be skipped.
- The FSM goes DATA -> IDLE with done after the last payload bit.
- ARM supplies any CRC bytes as payload.

Structure
REQ-029 The package felica_pkg SHALL hold:
- state enum;
- SYNC_WORD = 16'hB24D;
- CRC_POLY = 16'h1021;
- CRC_INIT = 16'h0000;
- half-bit constants 32/16.
REQ-030 A sub-module felica_crc16 SHALL compute the CRC (byte-wide update, clear, enable).

Verification
REQ-031 speed=0, bytes 06 00 FF FF 00 00, last on the sixth -> mod_out carries 00x6 B2 4D 06 00 FF FF 00 00 09 21; busy lasts 128*64 = 8192 cycles; done pulses once.
REQ-032 The same frame with speed=1 -> identical bit sequence, 16-cycle half-bits, 4096 cycles total.
REQ-033 Send 02 AA with tx_valid dropped before the second byte's boundary -> underrun pulse at the DATA byte boundary, mod_out = 0 next cycle, tx_ready = 1 in IDLE.
REQ-034 Assert rst at cycle 3000 of the REQ-031 frame -> mod_out = 0 next cycle, no done or underrun, a new frame starts cleanly afterwards.
REQ-035 FELICA_TX_CRC_EN undefined, REQ-031 bytes -> frame ends after 0x00, 112*64 = 7168 cycles, no 09 21.
REQ-036 Toggle speed at cycle 100 of a 212 frame -> bit timing stays 64 cycles per bit.
